// File: rtl/sys_defs.sv
// Shared types for the retire stage: physical tags, the ROB head packet,
// the retire FSM state and the registered store request.
package sys_defs;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 6;

    // Physical register tag with a valid qualifier.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } TAG;

    // ROB head entry presented to the retire stage.
    typedef struct packed {
        logic            retire_en;
        TAG              retire_t;
        TAG              retire_t_old;
        logic            halt;
        logic            wr_mem;
        logic [4:0]      dest_reg_idx;
        logic [XLEN-1:0] NPC;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] rs2_value;
        logic            take_branch;
    } ROB_IR_PACKET;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_ST_WAIT,
        RS_HALTED
    } RETIRE_STATE;

    // Store request held stable while waiting for the memory ack.
    typedef struct packed {
        logic            req;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } RETIRE_MEM_PACKET;

endpackage

// File: rtl/retire_stage.sv
// In-order retire stage. Commits the ROB head entry: frees the old physical
// tag, updates the architectural map, redirects fetch on taken branches,
// performs stores through a req/ack handshake and latches halt.
module retire_stage
    import sys_defs::*;
#(
    parameter int unsigned CNT_W = 64,
    parameter int unsigned PC_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  ROB_IR_PACKET       rob_ir_packet,
    output logic               ir_stall,
    output logic               free_en,
    output TAG                 free_tag,
    output logic               amt_wr_en,
    output logic [4:0]         amt_wr_idx,
    output TAG                 amt_wr_tag,
    output logic               redirect_en,
    output logic [PC_W-1:0]    redirect_pc,
    output logic               mem_req,
    output logic [XLEN-1:0]    mem_addr,
    output logic [XLEN-1:0]    mem_wdata,
    input  logic               mem_ack,
    output logic               halted,
    output logic [CNT_W-1:0]   retired_count
);

    RETIRE_STATE      state_q, state_d;
    RETIRE_MEM_PACKET mem_q, mem_d;
    TAG               st_t_old_q, st_t_old_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             commit;

    // NPC is carried in the packet but not needed to retire.
    logic unused_npc;
    assign unused_npc = ^rob_ir_packet.NPC;

    // State register; reset drops any in-flight store immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= RS_IDLE;
            mem_q      <= '0;
            st_t_old_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            st_t_old_q <= st_t_old_d;
            count_q    <= count_d;
        end
    end

    // Next-state: capture stores, wait for ack, latch halt, count commits.
    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        st_t_old_d = st_t_old_q;
        count_d    = count_q;
        case (state_q)
            RS_IDLE: begin
                if (rob_ir_packet.retire_en) begin
                    if (rob_ir_packet.wr_mem) begin
                        state_d    = RS_ST_WAIT;
                        mem_d.req   = 1'b1;
                        mem_d.addr  = rob_ir_packet.result;
                        mem_d.wdata = rob_ir_packet.rs2_value;
                        st_t_old_d = rob_ir_packet.retire_t_old;
                    end else if (rob_ir_packet.halt) begin
                        state_d = RS_HALTED;
                    end
                end
            end
            RS_ST_WAIT: begin
                if (mem_ack) begin
                    state_d   = RS_IDLE;
                    mem_d.req = 1'b0;
                end
            end
            RS_HALTED: state_d = RS_HALTED;
            default:   state_d = RS_IDLE;
        endcase
        if (commit) begin
            count_d = count_q + 1'b1;
        end
    end

    // Commit decode: all commit outputs are combinational and zero otherwise.
    always_comb begin
        commit      = 1'b0;
        free_en     = 1'b0;
        free_tag    = '0;
        amt_wr_en   = 1'b0;
        amt_wr_idx  = '0;
        amt_wr_tag  = '0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        case (state_q)
            RS_IDLE: begin
                if (rob_ir_packet.retire_en && !rob_ir_packet.wr_mem) begin
                    commit      = 1'b1;
                    free_en     = rob_ir_packet.retire_t_old.valid;
                    free_tag    = rob_ir_packet.retire_t_old;
                    amt_wr_en   = (rob_ir_packet.dest_reg_idx != 5'd0) &&
                                  rob_ir_packet.retire_t.valid;
                    amt_wr_idx  = rob_ir_packet.dest_reg_idx;
                    amt_wr_tag  = rob_ir_packet.retire_t;
                    redirect_en = rob_ir_packet.take_branch;
                    redirect_pc = rob_ir_packet.result[PC_W-1:0];
                end
            end
            RS_ST_WAIT: begin
                // Store commits on ack; it never writes the map.
                if (mem_ack) begin
                    commit   = 1'b1;
                    free_en  = st_t_old_q.valid;
                    free_tag = st_t_old_q;
                end
            end
            default: commit = 1'b0;
        endcase
        ir_stall = (state_q == RS_HALTED) || (rob_ir_packet.retire_en && !commit);
    end

    assign mem_req       = mem_q.req;
    assign mem_addr      = mem_q.addr;
    assign mem_wdata     = mem_q.wdata;
    assign halted        = (state_q == RS_HALTED);
    assign retired_count = count_q;

endmodule

// File: tb/tb_retire_stage.sv
// Scoreboard bench for retire_stage: the driver pushes the expected commit
// (computed from the retire rules) when it issues an entry; a monitor pops
// and compares whenever the ROB head is accepted.
module tb_retire_stage;
    import sys_defs::*;

    localparam int CNT_W = 64;
    localparam int PC_W  = 32;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    ROB_IR_PACKET       rob;
    logic               mem_ack;
    logic               ir_stall, free_en, amt_wr_en, redirect_en, mem_req, halted;
    TAG                 free_tag, amt_wr_tag;
    logic [4:0]         amt_wr_idx;
    logic [PC_W-1:0]    redirect_pc;
    logic [XLEN-1:0]    mem_addr, mem_wdata;
    logic [CNT_W-1:0]   retired_count;

    retire_stage #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .rob_ir_packet (rob),
        .ir_stall      (ir_stall),
        .free_en       (free_en),
        .free_tag      (free_tag),
        .amt_wr_en     (amt_wr_en),
        .amt_wr_idx    (amt_wr_idx),
        .amt_wr_tag    (amt_wr_tag),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .halted        (halted),
        .retired_count (retired_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        fe;
        TAG          ft;
        logic        ae;
        logic [4:0]  ai;
        TAG          at;
        logic        re;
        logic [31:0] rpc;
        logic [63:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mq[$];
    logic [63:0] model_cnt = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic TAG tg(input int v, input int t);
        TAG x;
        x.valid = v[0];
        x.tag   = t[TAG_W-1:0];
        return x;
    endfunction

    function automatic ROB_IR_PACKET mk(input bit st, input bit br, input bit hlt,
                                        input logic [4:0] d, input TAG t, input TAG to,
                                        input logic [31:0] res, input logic [31:0] rs2);
        ROB_IR_PACKET p;
        p.retire_en    = 1'b1;
        p.retire_t     = t;
        p.retire_t_old = to;
        p.halt         = hlt;
        p.wr_mem       = st;
        p.dest_reg_idx = d;
        p.NPC          = res + 32'd4;
        p.result       = res;
        p.rs2_value    = rs2;
        p.take_branch  = br;
        return p;
    endfunction

    // Monitor: compare on every accepted head, otherwise require silence.
    exp_t        mon_e;
    logic [63:0] cur_mem;
    bit          prev_req = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            if (rob.retire_en && !ir_stall) begin
                if (sb.size() == 0) begin
                    check("unexpected_commit", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("free_en", free_en, mon_e.fe);
                    if (mon_e.fe) check("free_tag", free_tag, mon_e.ft);
                    check("amt_wr_en", amt_wr_en, mon_e.ae);
                    if (mon_e.ae) begin
                        check("amt_wr_idx", amt_wr_idx, mon_e.ai);
                        check("amt_wr_tag", amt_wr_tag, mon_e.at);
                    end
                    check("redirect_en", redirect_en, mon_e.re);
                    if (mon_e.re) check("redirect_pc", redirect_pc, mon_e.rpc);
                    check("retired_count", retired_count, mon_e.cnt);
                end
            end else begin
                check("quiet_no_commit", {free_en, amt_wr_en, redirect_en}, 64'd0);
            end
            if (mem_req && !prev_req) begin
                if (mq.size() == 0) begin
                    check("unexpected_mem_req", 64'd1, 64'd0);
                end else begin
                    cur_mem = mq.pop_front();
                    check("mem_addr_data", {mem_addr, mem_wdata}, cur_mem);
                end
            end else if (mem_req) begin
                check("mem_stable", {mem_addr, mem_wdata}, cur_mem);
            end
            prev_req = mem_req;
        end else begin
            prev_req = 1'b0;
        end
    end

    // Present one head entry until accepted; ack stores after ack_delay cycles of req.
    task automatic issue(input ROB_IR_PACKET p, input int ack_delay,
                         output int acc_idx, output int req_idx);
        exp_t e;
        bit   acc, saw;
        int   waited;
        e.fe  = p.retire_t_old.valid;
        e.ft  = p.retire_t_old;
        e.ae  = !p.wr_mem && (p.dest_reg_idx != 0) && p.retire_t.valid;
        e.ai  = p.dest_reg_idx;
        e.at  = p.retire_t;
        e.re  = !p.wr_mem && p.take_branch;
        e.rpc = p.result;
        e.cnt = model_cnt;
        sb.push_back(e);
        model_cnt++;
        if (p.wr_mem) mq.push_back({p.result, p.rs2_value});
        rob     = p;
        mem_ack = 1'b0;
        acc_idx = -1;
        req_idx = -1;
        waited  = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            acc = !ir_stall;
            saw = mem_req;
            if (saw && req_idx < 0) req_idx = k;
            @(posedge clock);
            #1;
            if (acc) begin
                acc_idx = k;
                break;
            end
            if (saw) begin
                waited++;
                mem_ack = (waited >= ack_delay);
            end
        end
        rob.retire_en = 1'b0;
        mem_ack       = 1'b0;
        if (acc_idx < 0) check("accept_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int          a, r, d, gap;
        bit          st;
        logic [63:0] hcnt;
        rob     = '0;
        mem_ack = 1'b0;
        reset   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_mem_req", mem_req, 64'd0);
        check("rst_halted", halted, 64'd0);
        check("rst_count", retired_count, 64'd0);
        check("rst_stall", ir_stall, 64'd0);
        check("rst_commit_outs", {free_en, amt_wr_en, redirect_en}, 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        issue(mk(1'b0, 1'b0, 1'b0, 5'd5, tg(1, 12), tg(1, 3), 32'h1234, 32'h0), 0, a, r);
        check("alu_latency", a, 64'd0);
        check("count_after_alu", retired_count, 64'd1);

        issue(mk(1'b1, 1'b0, 1'b0, 5'd7, tg(1, 20), tg(1, 9), 32'h100, 32'hAB), 3, a, r);
        check("store_req_latency", r, 64'd1);
        check("store_commit_latency", a, 64'd4);

        issue(mk(1'b0, 1'b1, 1'b0, 5'd0, tg(0, 0), tg(0, 0), 32'h40, 32'h0), 0, a, r);
        @(negedge clock);
        check("redirect_pulse_gone", redirect_en, 64'd0);
        @(posedge clock);
        #1;

        issue(mk(1'b0, 1'b0, 1'b0, 5'd0, tg(1, 7), tg(1, 9), 32'h8, 32'h0), 0, a, r);

        for (int i = 0; i < 150; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                mem_ack = 1'($urandom_range(0, 1));
                @(posedge clock);
                #1;
            end
            mem_ack = 1'b0;
            st = ($urandom_range(0, 3) == 0);
            d  = $urandom_range(1, 4);
            issue(mk(st, 1'($urandom_range(0, 1)), 1'b0, 5'($urandom_range(0, 31)),
                     tg($urandom_range(0, 1), $urandom_range(0, 63)),
                     tg($urandom_range(0, 1), $urandom_range(0, 63)),
                     $urandom, $urandom), d, a, r);
            if (st) check("rand_store_latency", a, d + 1);
            else    check("rand_alu_latency", a, 64'd0);
        end
        check("count_after_random", retired_count, model_cnt);

        issue(mk(1'b0, 1'b0, 1'b1, 5'd3, tg(1, 5), tg(1, 6), 32'h0, 32'h0), 0, a, r);
        check("halted_set", halted, 64'd1);
        hcnt = model_cnt;
        rob  = mk(1'b0, 1'b0, 1'b0, 5'd4, tg(1, 1), tg(1, 2), 32'h0, 32'h0);
        repeat (5) begin
            @(negedge clock);
            check("halted_stall", ir_stall, 64'd1);
            check("halted_count", retired_count, hcnt);
        end
        rob.retire_en = 1'b0;
        @(negedge clock);
        check("halted_sticky", {halted, ir_stall}, 64'd3);

        // Reset mid-store: request must drop asynchronously, count cleared.
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
        mq.delete();
        model_cnt = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        check("rst2_halted", halted, 64'd0);
        mq.push_back({32'h200, 32'hCD});
        rob = mk(1'b1, 1'b0, 1'b0, 5'd1, tg(1, 1), tg(1, 2), 32'h200, 32'hCD);
        @(negedge clock);
        @(negedge clock);
        check("store_req_before_reset", mem_req, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mem_req_async_drop", mem_req, 64'd0);
        check("count_in_reset", retired_count, 64'd0);
        rob.retire_en = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("post_reset_req", mem_req, 64'd0);
        check("post_reset_count", retired_count, 64'd0);
        issue(mk(1'b0, 1'b0, 1'b0, 5'd9, tg(1, 30), tg(1, 31), 32'h0, 32'h0), 0, a, r);
        check("post_reset_idle_commit", a, 64'd0);
        check("post_reset_count1", retired_count, 64'd1);

        check("sb_drained", sb.size(), 64'd0);
        check("mq_drained", mq.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
